// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Round-robin arbiter that owns the select lines {s1, s0} of a shared 4:1 mux.
//   One requester holds the grant at a time, for at most MAX_HOLD consecutive
//   cycles. The owner's data word is registered onto out_data, and out_valid
//   reports whether the owner was still requesting when that word was captured.
//   Optional build macro: MUX_ARB_LOCK_EN. It adds a 'lock' input that lets the
//   current owner keep the grant beyond MAX_HOLD while it keeps requesting.

module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        req,
`ifdef MUX_ARB_LOCK_EN
  input  logic              lock,
`endif
  input  logic [DATA_W-1:0] i0,
  input  logic [DATA_W-1:0] i1,
  input  logic [DATA_W-1:0] i2,
  input  logic [DATA_W-1:0] i3,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  // hold_cnt only has to reach MAX_HOLD-1; keep at least one bit for MAX_HOLD==1
  localparam int              HC_W      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        gnt_r;
  logic [3:0]        gnt_s;
  logic [1:0]        sel_r;
  logic [1:0]        sel_s;
  logic [1:0]        last_r;
  logic [1:0]        last_s;
  logic [HC_W-1:0]   hold_cnt_r;
  logic [HC_W-1:0]   hold_cnt_s;
  logic [DATA_W-1:0] out_data_r;
  logic [DATA_W-1:0] out_data_s;
  logic              out_valid_r;
  logic              out_valid_s;

  logic [DATA_W-1:0] mux_data_s;
  logic              owner_req_s;
  logic              lock_hold_s;
  logic              release_s;
  logic [2:0]        pick_s;

  // Round-robin scan: first active request after last_v, wrapping so that
  // last_v itself is examined last. Returns {found, index}.
  function automatic logic [2:0] rr_pick(input logic [3:0] req_v, input logic [1:0] last_v);
    logic [2:0] res_v;
    logic [1:0] idx_v;
    res_v = 3'b000;
    // Walk from lowest to highest priority so the nearest hit wins
    for (int d = 4; d >= 1; d--) begin
      idx_v = last_v + 2'(d);
      if (req_v[idx_v]) begin
        res_v = {1'b1, idx_v};
      end else begin
        res_v = res_v;
      end
    end
    return res_v;
  endfunction

  // The shared 4:1 mux, steered by the registered select
  always_comb begin
    mux_data_s = i0;
    case (sel_r)
      2'd0:    mux_data_s = i0;
      2'd1:    mux_data_s = i1;
      2'd2:    mux_data_s = i2;
      2'd3:    mux_data_s = i3;
      default: mux_data_s = i0;
    endcase
  end

  assign owner_req_s = req[sel_r];

`ifdef MUX_ARB_LOCK_EN
  assign lock_hold_s = lock & owner_req_s;
`else
  assign lock_hold_s = 1'b0;
`endif

  // Owner gives up the grant when it stops requesting or uses up its slot
  assign release_s = (~owner_req_s) | ((hold_cnt_r == HOLD_LAST) & (~lock_hold_s));

  // While busy the scan starts after the owner, which becomes 'last' on release
  assign pick_s = rr_pick(req, (state_r == ST_BUSY) ? sel_r : last_r);

  // Next-state, grant, select and output-data decisions
  always_comb begin
    state_s     = state_r;
    gnt_s       = gnt_r;
    sel_s       = sel_r;
    last_s      = last_r;
    hold_cnt_s  = hold_cnt_r;
    out_data_s  = out_data_r;
    out_valid_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_s[2]) begin
          state_s    = ST_BUSY;
          gnt_s      = 4'b0001 << pick_s[1:0];
          sel_s      = pick_s[1:0];
          hold_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
          gnt_s   = 4'b0000;
        end
      end
      ST_BUSY: begin
        out_data_s  = mux_data_s;
        out_valid_s = owner_req_s;
        if (release_s) begin
          last_s     = sel_r;
          hold_cnt_s = '0;
          if (pick_s[2]) begin
            // Hand over in the same edge: no idle bubble between owners
            state_s = ST_BUSY;
            gnt_s   = 4'b0001 << pick_s[1:0];
            sel_s   = pick_s[1:0];
          end else begin
            // Nobody left: drop the grant but keep sel where it was
            state_s = ST_IDLE;
            gnt_s   = 4'b0000;
          end
        end else begin
          if (hold_cnt_r != HOLD_LAST) begin
            hold_cnt_s = hold_cnt_r + HC_W'(1);
          end else begin
            hold_cnt_s = hold_cnt_r;
          end
        end
      end
      default: begin
        state_s    = ST_IDLE;
        gnt_s      = 4'b0000;
        hold_cnt_s = '0;
      end
    endcase
  end

  // State and output registers; reset gives requester 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      gnt_r       <= 4'b0000;
      sel_r       <= 2'd0;
      last_r      <= 2'd3;
      hold_cnt_r  <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      gnt_r       <= gnt_s;
      sel_r       <= sel_s;
      last_r      <= last_s;
      hold_cnt_r  <= hold_cnt_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
    end
  end

  assign gnt       = gnt_r;
  assign sel       = sel_r;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;

endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 multiplexer between four requesters.
- Each requester presents a data word and a request bit.
- The block grants one requester at a time and drives the mux select {s1, s0} for that requester.
- It registers the selected data onto a single output with a valid flag.
- It sits directly in front of the existing 4:1 mux datapath and owns its select lines.

Parameters:
- DATA_W, 1: width of each data input and of out_data (1 matches the existing mux).
- MAX_HOLD, 4: maximum consecutive cycles one requester may keep the grant. Legal range 1..255.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request bits; req[k] belongs to requester k.
- i0  input  DATA_W  data of requester 0.
- i1  input  DATA_W  data of requester 1.
- i2  input  DATA_W  data of requester 2.
- i3  input  DATA_W  data of requester 3.
- gnt  output  4  registered one-hot grant; all zero when idle.
- sel  output  2  registered mux select {s1, s0}; equals the index of the asserted gnt bit.
- out_data  output  DATA_W  registered selected data.
- out_valid  output  1  out_data carries a word from the granted, still-requesting requester.

Behaviour:
- Reset (rst_n low, asynchronous, also mid-transfer):
  - gnt=0, sel=0, out_data=0, out_valid=0.
  - state=IDLE, hold_cnt=0, last=3, so requester 0 has first priority after reset.
  - On deassertion, normal operation resumes at the next rising edge.
- State IDLE (gnt=0):
  - If req==0, stay in IDLE.
  - Otherwise, at the next edge, grant the first k with req[k]=1, scanning last+1, last+2, last+3, last (mod 4).
  - On the grant: gnt[k]=1, sel=k, hold_cnt=0, state goes to BUSY.
- State BUSY, owner k, each edge:
  - out_data <= i[k], out_valid <= req[k].
  - Release when req[k]==0 or hold_cnt==MAX_HOLD-1.
  - Otherwise hold_cnt increments.
- On release:
  - last <= k.
  - In the same edge, re-arbitrate over the current req using the scan order starting at k+1.
  - If a winner exists, gnt/sel switch directly to it with hold_cnt=0. There is no idle bubble.
  - If no requester is active, go to IDLE with gnt=0 and sel held at its last value.
  - A sole remaining requester k that timed out is re-granted immediately, since k is last in the scan.
- Latency:
  - req[k] rising at edge N while IDLE gives gnt[k] after edge N+1.
  - The first valid out_data for k appears after edge N+2.
  - out_valid drops one edge after the owner drops req or the grant moves.
- Counters and widths:
  - hold_cnt is wide enough for MAX_HOLD-1.
  - sel and last wrap modulo 4.
- Invariants:
  - gnt is always one-hot or zero.
  - sel==index(gnt) whenever gnt!=0.
  - No requester waits more than 3*MAX_HOLD+1 cycles while continuously requesting.

Optional Feature:
- Macro MUX_ARB_LOCK_EN.
- When defined:
  - Add input port lock (1 bit), placed after req.
  - While lock=1 and req[k]=1 for the current owner k, the MAX_HOLD timeout is suppressed and hold_cnt saturates at MAX_HOLD-1.
  - Release happens only when req[k] drops.
  - lock has no effect in IDLE.
- When not defined:
  - No lock port.
  - The MAX_HOLD timeout always applies.

Test Plan:
- Reset: drive rst_n=0 mid-BUSY with gnt=4'b0100. Expect gnt=0, sel=0, out_valid=0, out_data=0 immediately, without waiting for a clock edge. Then release reset and set req=4'b1111; expect gnt=4'b0001 after one edge.
- Single requester: req=4'b0100, i2=1, MAX_HOLD=4. Expect gnt=4'b0100 and sel=2 after edge 1. Expect out_data=1, out_valid=1 from edge 2. After 4 BUSY cycles, expect a regrant to 2 with no gnt=0 cycle.
- Round robin: req=4'b1111 held constant, MAX_HOLD=2. Expect owner sequence 0,0,1,1,2,2,3,3,0,..., with sel tracking each owner.
- Early release: owner 1 drops req after 1 cycle while req[3]=1. Expect gnt=4'b1000 on the next edge, with out_valid=0 for that one cycle.
- Full mux sweep: for all 64 values of {sel target, i3..i0}, grant the target requester and check out_data==i[target] one cycle after the grant.
- MUX_ARB_LOCK_EN: lock=1, req=4'b0011, owner 0, MAX_HOLD=2. Expect owner 0 to hold the grant for 10 cycles. Then drop req[0]; expect gnt=4'b0010 on the next edge.
